// File: rtl/mult_defs_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t     : controller states {IDLE, RUN, DONE}
//   MULT_WIDTH  : default operand width (MIPS rs/rt)
//   CNT_W       : iteration counter width for the default operand width
package mult_defs_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int CNT_W      = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_addshift_step.sv
// One shift-and-add iteration, purely combinational.
// Ports:
//   acc_hi      in  WIDTH  upper half of the running product
//   mplier      in  WIDTH  remaining multiplier bits (bit 0 is consumed now)
//   mcand       in  WIDTH  multiplicand magnitude
//   sum_hi      out WIDTH  acc_hi plus mcand when mplier[0] is set, before the shift
//   carry       out 1      carry out of that WIDTH+1-bit add
//   mplier_next out WIDTH  multiplier shifted right by one, zero filled
// The caller performs the right shift of {carry, sum_hi, acc_lo}.
module mult_addshift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] mplier,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] sum_hi,
    output logic             carry,
    output logic [WIDTH-1:0] mplier_next
);

    logic [WIDTH:0] addend;

    always_comb begin
        addend          = mplier[0] ? {1'b0, mcand} : '0;
        {carry, sum_hi} = {1'b0, acc_hi} + addend;
        // Zero fill keeps "remaining multiplier bits" meaningful for the
        // early-exit test; the fixed-length build never looks at these bits.
        mplier_next     = {1'b0, mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_shift_seq.sv
// Sequential shift-and-add multiplier (MIPS MULT/MULTU -> HI/LO).
// One multiplier bit per cycle; signed operation is done on magnitudes and
// the sign is applied to the final 2*WIDTH product.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a multiply; honoured only in IDLE or DONE
//   signed_op  in   1      1 = MULT (two's complement), 0 = MULTU
//   a          in   WIDTH  multiplicand (rs)
//   b          in   WIDTH  multiplier (rt)
//   busy       out  1      high while iterating
//   done       out  1      one-cycle pulse; hi/lo valid in the same cycle
//   hi, lo     out  WIDTH  product words, held until the next done
// Build option: MULT_EARLY_EXIT_EN ends the iteration as soon as the
// remaining multiplier bits are all zero and realigns the accumulator.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add/shift step per cycle
// DONE  | sign-correct accumulator, load hi/lo (done pulses next cycle)
module mult_shift_seq
    import mult_defs_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

    state_t               state, state_next;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;
    logic [CNT_BITS-1:0]  count;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 accept;
    logic                 run_exit;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     sum_hi, mplier_step;
    logic                 carry;
    logic [2*WIDTH-1:0]   acc_next, acc_run, product;

    mult_addshift_step #(.WIDTH(WIDTH)) u_step (
        .acc_hi      (acc[2*WIDTH-1:WIDTH]),
        .mplier      (mplier),
        .mcand       (mcand),
        .sum_hi      (sum_hi),
        .carry       (carry),
        .mplier_next (mplier_step)
    );

    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        mag_a    = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b    = (signed_op && b[WIDTH-1]) ? -b : b;
        acc_next = {carry, sum_hi, acc[WIDTH-1:1]};
`ifdef MULT_EARLY_EXIT_EN
        run_exit = (count == LAST_CNT) || (mplier_step == '0);
        // After count+1 steps the product sits WIDTH-1-count bits too high.
        acc_run  = run_exit ? (acc_next >> (LAST_CNT - count)) : acc_next;
`else
        run_exit = (count == LAST_CNT);
        acc_run  = acc_next;
`endif
        product  = neg ? -acc : acc;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)   state_next = RUN;
            RUN:  if (run_exit) state_next = DONE;
            DONE: state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= acc_run;
            mplier <= mplier_step;
            count  <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= (state == DONE);
            if (state == DONE) begin
                hi_q <= product[2*WIDTH-1:WIDTH];
                lo_q <= product[WIDTH-1:0];
            end
        end
    end

    assign busy = (state == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_shift_seq.sv
// Self-checking bench for mult_shift_seq (WIDTH = 32).
// Expected products are pushed to a scoreboard when a start is accepted and
// popped by a monitor whenever done pulses. Latency expectations follow the
// build: fixed 33 cycles, or 2 + highest set bit of |b| with MULT_EARLY_EXIT_EN.
module tb_mult_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    mult_shift_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(bit sgn, logic [31:0] av, logic [31:0] bv);
        logic signed [63:0] sa, sbv;
        if (sgn) begin
            sa  = {{32{av[31]}}, av};
            sbv = {{32{bv[31]}}, bv};
            return sa * sbv;
        end
        return {32'b0, av} * {32'b0, bv};
    endfunction

    function automatic int exp_latency(bit sgn, logic [31:0] bv);
`ifdef MULT_EARLY_EXIT_EN
        logic [31:0] m;
        int h;
        m = (sgn && bv[31]) ? -bv : bv;
        h = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) h = i;
        return 2 + h;
`else
        return (sgn && bv[31]) ? 33 : 33;
`endif
    endfunction

    // Scoreboard monitor: samples mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                check("product", {hi, lo}, sb.pop_front());
            end
        end
    end

    // Drive one start pulse; returns #1 after the accepting edge.
    task automatic issue(bit sgn, logic [31:0] av, logic [31:0] bv);
        signed_op = sgn;
        a         = av;
        b         = bv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(sgn, av, bv));
    endtask

    // Wait for done counting edges from the accept edge; optionally pulse a
    // spurious start with different operands at cycle inj_at.
    task automatic await_done(string tag, logic [63:0] exp, int exp_lat, int lat0, int inj_at);
        int lat;
        int busy_cnt;
        bit seen;
        lat      = lat0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (lat < 200) begin
            if (lat == inj_at) begin
                start     = 1'b1;
                a         = 32'hDEAD_BEEF;
                b         = 32'h0000_0003;
                signed_op = ~signed_op;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (!seen) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1 - lat0));
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, 64'(done), 64'd0);
            check({tag, "_hold"}, {hi, lo}, exp);
        end
    endtask

    task automatic mult_op(string tag, bit sgn, logic [31:0] av, logic [31:0] bv);
        issue(sgn, av, bv);
        await_done(tag, model(sgn, av, bv), exp_latency(sgn, bv), 0, -1);
    endtask

    task automatic back_to_back(logic [31:0] a1, logic [31:0] b1, logic [31:0] a2, logic [31:0] b2);
        int lat;
        issue(1'b0, a1, b1);
        lat = 0;
        while (busy && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_wait", 64'(lat < 100), 64'd1);
        // busy just fell: the controller is in DONE, so this start is taken there.
        issue(1'b1, a2, b2);
        check("b2b_done_first", 64'(done), 64'd1);
        check("b2b_busy_second", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check("b2b_done_drop", 64'(done), 64'd0);
        await_done("b2b_second", model(1'b1, a2, b2), exp_latency(1'b1, b2), 1, -1);
    endtask

    initial begin
        int n_done;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        mult_op("multu_3x5",     1'b0, 32'd3,         32'd5);
        mult_op("mult_m2x7",     1'b1, 32'hFFFF_FFFE, 32'd7);
        mult_op("multu_ffxff",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mult_op("mult_ffxff",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mult_op("mult_minxmin",  1'b1, 32'h8000_0000, 32'h8000_0000);
        mult_op("multu_zero_a",  1'b0, 32'd0,         32'h1234_5678);
        mult_op("mult_zero_b",   1'b1, 32'h8765_4321, 32'd0);
        mult_op("multu_bx1",     1'b0, 32'h1234_5678, 32'd1);
        mult_op("mult_pos_neg",  1'b1, 32'd12345,     32'hFFFF_F000);
        mult_op("multu_topbit",  1'b0, 32'd3,         32'h8000_0001);

        issue(1'b0, 32'd1000, 32'd3000);
        await_done("ignore_mid_start", model(1'b0, 32'd1000, 32'd3000),
                   exp_latency(1'b0, 32'd3000), 0, 1);

        back_to_back(32'h0000_ABCD, 32'h8000_0000, 32'hFFFF_FFF0, 32'h0000_0101);

        mult_op("pre_abort", 1'b0, 32'h0001_0001, 32'h0002_0000);
        issue(1'b0, 32'h0000_ABCD, 32'h7000_1234);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        mult_op("after_abort", 1'b1, 32'hFFFF_FF00, 32'h0000_0321);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            bit rs;
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            mult_op("random", rs, ra, rb);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
